// File: rtl/mem_io_responder.sv
// Responder for the CPU byte-wide bus: 2^RAM_AW-byte RAM, rx/tx byte FIFOs and a cycle counter.
// Read data is registered and appears one cycle after the access; IO stalls drop cpu_rdy_out.
module mem_io_responder #(
    parameter int unsigned RAM_AW     = 17,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a_in,
    input  logic        cpu_wr_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_rdy_out,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in,
    output logic        rx_ready_out,
    output logic        tx_valid_out,
    output logic [7:0]  tx_data_out,
    input  logic        tx_ready_in,
    output logic        halt_out
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [17:0] addr;
    logic        unused_addr;
    logic        sel_ram;
    logic        io_data;
    logic        io_cnt;
    logic        io_stop;

    assign addr        = cpu_a_in[17:0];
    assign unused_addr = ^cpu_a_in[31:18];
    assign sel_ram     = !addr[17];
    assign io_data     = addr == 18'h30000;
    assign io_cnt      = addr[17:2] == 16'hC001;
    assign io_stop     = addr == 18'h30004;

    logic [7:0]  ram [2**RAM_AW];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [PW:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic        rx_full, rx_empty, tx_full, tx_empty;
    logic        rx_push, rx_pop, tx_push, tx_pop, tx_req;
    logic [7:0]  tx_wdata;
    logic [7:0]  rdata_q, rdata_d;
    logic [31:0] cnt_q, snap_q, snap_d;
    logic        halt_q;

    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[PW] != rx_rp_q[PW]) && (rx_wp_q[PW-1:0] == rx_rp_q[PW-1:0]);
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[PW] != tx_rp_q[PW]) && (tx_wp_q[PW-1:0] == tx_rp_q[PW-1:0]);

    assign rx_ready_out  = !rx_full;
    assign tx_valid_out  = !tx_empty;
    assign tx_data_out   = tx_mem[tx_rp_q[PW-1:0]];
    assign cpu_rdata_out = rdata_q;
    assign halt_out      = halt_q;

    always_comb begin
        tx_req   = cpu_wr_in && ((io_data && cpu_wdata_in != 8'h00) || io_stop);
        tx_pop   = !tx_empty && tx_ready_in;
        // No rx bypass: an empty FIFO stalls even if a byte arrives this cycle.
        // A tx pop frees the slot, so a full FIFO still takes a same-cycle push.
        cpu_rdy_out = !((!cpu_wr_in && io_data && rx_empty) || (tx_req && tx_full && !tx_pop));
        rx_push  = rx_valid_in && !rx_full;
        rx_pop   = cpu_rdy_out && !cpu_wr_in && io_data;
        tx_push  = cpu_rdy_out && tx_req;
        tx_wdata = io_stop ? 8'h00 : cpu_wdata_in;
    end

    always_comb begin
        rdata_d = rdata_q;
        snap_d  = snap_q;
        if (cpu_rdy_out && !cpu_wr_in) begin
            if (sel_ram) begin
                rdata_d = ram[cpu_a_in[RAM_AW-1:0]];
            end else if (io_data) begin
                rdata_d = rx_mem[rx_rp_q[PW-1:0]];
            end else if (io_cnt) begin
                unique case (addr[1:0])
                    2'd0: begin
                        rdata_d = cnt_q[7:0];
                        snap_d  = cnt_q;
                    end
                    2'd1: rdata_d = snap_q[15:8];
                    2'd2: rdata_d = snap_q[23:16];
                    2'd3: rdata_d = snap_q[31:24];
                endcase
            end else begin
                rdata_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rdata_q <= 8'h00;
            cnt_q   <= 32'd0;
            snap_q  <= 32'd0;
            halt_q  <= 1'b0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_q + 32'd1;
            if (cpu_rdy_out && cpu_wr_in && io_stop) halt_q <= 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + PTR_ONE;
            if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_ONE;
            if (tx_push) tx_wp_q <= tx_wp_q + PTR_ONE;
            if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_ONE;
        end
    end

    // Storage arrays carry no reset; RAM contents survive reset.
    always_ff @(posedge clk_in) begin
        if (cpu_rdy_out && cpu_wr_in && sel_ram) ram[cpu_a_in[RAM_AW-1:0]] <= cpu_wdata_in;
        if (rx_push) rx_mem[rx_wp_q[PW-1:0]] <= rx_data_in;
        if (tx_push) tx_mem[tx_wp_q[PW-1:0]] <= tx_wdata;
    end

endmodule
